// File: rtl/psum_collector_pkg.sv
// Shared types and constants for the psum collector: PE packet format,
// per-layer ofmap sizes, fixed-point widths and the psum-to-ofmap conversion.
package psum_collector_pkg;

  localparam int L1_OFMAP_SIZE = 55;
  localparam int L2_OFMAP_SIZE = 27;
  localparam int L3_OFMAP_SIZE = 13;

  localparam int NUM_FILTERS = 4;
  localparam int ADDR_W      = 6;

  localparam int PSUM_W     = 12;
  localparam int PSUM_FRAC  = 5;
  localparam int OFMAP_W    = 8;
  localparam int OFMAP_FRAC = 7;
  localparam int FRAC_SHIFT = OFMAP_FRAC - PSUM_FRAC;

  typedef struct packed {
    logic                     valid;
    logic [1:0]               filter_idx;
    logic signed [PSUM_W-1:0] psum;
  } psum_packet_t;

  // What the FIFO holds: the packet minus its valid qualifier.
  typedef struct packed {
    logic [1:0]               filter_idx;
    logic signed [PSUM_W-1:0] psum;
  } psum_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Rescale to the ofmap fraction, saturate to the 8-bit signed range, optional ReLU.
  function automatic logic [OFMAP_W-1:0] psum_to_ofmap(
    input logic signed [PSUM_W-1:0] psum,
    input logic                     relu_en
  );
    logic signed [PSUM_W+FRAC_SHIFT-1:0] scaled;
    logic [OFMAP_W-1:0]                  res;
    scaled = {psum, {FRAC_SHIFT{1'b0}}};
    if (!scaled[PSUM_W+FRAC_SHIFT-1] && (|scaled[PSUM_W+FRAC_SHIFT-2:OFMAP_W-1]))
      res = {1'b0, {(OFMAP_W-1){1'b1}}};
    else if (scaled[PSUM_W+FRAC_SHIFT-1] && !(&scaled[PSUM_W+FRAC_SHIFT-2:OFMAP_W-1]))
      res = {1'b1, {(OFMAP_W-1){1'b0}}};
    else
      res = scaled[OFMAP_W-1:0];
    if (relu_en && res[OFMAP_W-1])
      res = '0;
    return res;
  endfunction

endpackage

// File: rtl/psum_collector_if.sv
// PE-side psum handshake and ofmap-buffer write port of the psum collector.
// psum: PE holds psum_in.valid until a one-cycle psum_ack; ofmap: a write completes on a cycle with ofmap_valid && ofmap_ready.
interface psum_collector_if;
  import psum_collector_pkg::*;

  psum_packet_t        psum_in;
  logic                psum_ack;
  logic                ofmap_valid;
  logic [1:0]          ofmap_filter_idx;
  logic [ADDR_W-1:0]   ofmap_addr;
  logic [OFMAP_W-1:0]  ofmap_data;
  logic                ofmap_ready;

  modport master (
    output psum_in, ofmap_ready,
    input  psum_ack, ofmap_valid, ofmap_filter_idx, ofmap_addr, ofmap_data
  );

  modport slave (
    input  psum_in, ofmap_ready,
    output psum_ack, ofmap_valid, ofmap_filter_idx, ofmap_addr, ofmap_data
  );

endinterface

// File: rtl/psum_fifo.sv
// Small circular FIFO of arbitrary entry type; push and pop may happen together.
// Caller must not push when full; flush empties it in one cycle.
module psum_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic empty,
  output logic full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/psum_collector.sv
// Collects PE psums per filter, converts them to the next-layer 8-bit format
// and writes them to the ofmap buffer with per-filter column addressing.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int OFMAP_SIZE = L1_OFMAP_SIZE,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  psum_collector_if.slave    bus,
  output logic               done,
  output logic               error,
  output state_t             state_dbg
);

  localparam logic [ADDR_W-1:0] SIZE = ADDR_W'(OFMAP_SIZE);

  state_t             state;
  state_t             state_next;
  logic [ADDR_W-1:0]  col_cnt [NUM_FILTERS];

  psum_entry_t        head;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_pop;

  logic               accepting;
  logic               capture;
  logic               write_fire;
  logic               head_full;
  logic               drop;
  logic               load;
  logic               all_full;
  logic [OFMAP_W-1:0] conv_data;

  psum_fifo #(
    .T     (psum_entry_t),
    .DEPTH (2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (start),
    .push      (capture),
    .push_data ({bus.psum_in.filter_idx, bus.psum_in.psum}),
    .pop       (fifo_pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // A start cycle flushes everything, so nothing is captured or drained during it.
  assign accepting  = (state != ST_IDLE) && !start;
  assign capture    = accepting && bus.psum_in.valid && !bus.psum_ack && !fifo_full;
  assign write_fire = bus.ofmap_valid && bus.ofmap_ready;
  assign head_full  = (col_cnt[head.filter_idx] == SIZE);
  assign drop       = accepting && !fifo_empty && !bus.ofmap_valid && head_full;
  assign load       = accepting && !fifo_empty && !bus.ofmap_valid && !head_full;
  assign fifo_pop   = write_fire || drop;

  assign done      = (state == ST_DONE);
  assign state_dbg = state;

  always_comb begin
    conv_data = psum_to_ofmap(head.psum, RELU_EN);
  end

  always_comb begin
    all_full = 1'b1;
    for (int i = 0; i < NUM_FILTERS; i++)
      if (col_cnt[i] != SIZE) all_full = 1'b0;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        if (start)                       state_next = ST_RUN;
        else if (all_full && fifo_empty) state_next = ST_DONE;
      end
      ST_DONE: if (start) state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.psum_ack <= 1'b0;
      error        <= 1'b0;
      for (int i = 0; i < NUM_FILTERS; i++) col_cnt[i] <= '0;
    end else begin
      bus.psum_ack <= capture;
      if (start) begin
        error <= 1'b0;
        for (int i = 0; i < NUM_FILTERS; i++) col_cnt[i] <= '0;
      end else begin
        if (drop) error <= 1'b1;
        if (write_fire)
          col_cnt[bus.ofmap_filter_idx] <= col_cnt[bus.ofmap_filter_idx] + ADDR_W'(1);
      end
    end
  end

  // Output stage mirrors the FIFO head; it is released (with a one-cycle gap) once the write completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ofmap_valid      <= 1'b0;
      bus.ofmap_filter_idx <= '0;
      bus.ofmap_addr       <= '0;
      bus.ofmap_data       <= '0;
    end else if (start || write_fire) begin
      bus.ofmap_valid <= 1'b0;
    end else if (load) begin
      bus.ofmap_valid      <= 1'b1;
      bus.ofmap_filter_idx <= head.filter_idx;
      bus.ofmap_addr       <= col_cnt[head.filter_idx];
      bus.ofmap_data       <= conv_data;
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
// Randomised self-checking bench for psum_collector against a queue-based
// reference model of the expected ofmap writes.
module tb_psum_collector;
  import psum_collector_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   start;
  logic   start2;
  logic   done, error, done2, error2;
  state_t state_dbg, state_dbg2;

  psum_collector_if bus ();
  psum_collector_if bus2 ();

  psum_collector #(.OFMAP_SIZE(L1_OFMAP_SIZE), .RELU_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus.slave),
    .done(done), .error(error), .state_dbg(state_dbg)
  );

  psum_collector #(.OFMAP_SIZE(4), .RELU_EN(1'b0)) dut_norelu (
    .clk(clk), .rst(rst), .start(start2), .bus(bus2.slave),
    .done(done2), .error(error2), .state_dbg(state_dbg2)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  int          model_cnt[4];
  logic        model_err;
  int          write_cnt = 0;
  int          ack_cnt = 0;
  int          ready_mode = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] stall_word;

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_conv(input int p, input bit relu);
    int v;
    v = p * 4;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    if (relu && v < 0) v = 0;
    return 8'(v);
  endfunction

  function automatic void model_accept(input logic [1:0] f, input logic signed [11:0] p);
    if (model_cnt[f] < L1_OFMAP_SIZE) begin
      exp_q.push_back({f, 6'(model_cnt[f]), ref_conv(int'(p), 1'b1)});
      model_cnt[f]++;
    end else begin
      model_err = 1'b1;
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) model_cnt[i] = 0;
    model_err = 1'b0;
    exp_q.delete();
  endfunction

  // ---------------- ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.ofmap_ready = 1'b1;
      1:       bus.ofmap_ready = ($urandom_range(0, 3) != 0);
      default: bus.ofmap_ready = 1'b0;
    endcase
  end

  // ---------------- write monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [15:0] got;
    logic [15:0] e;
    got = {bus.ofmap_filter_idx, bus.ofmap_addr, bus.ofmap_data};
    if (rst && bus.psum_ack) ack_cnt++;
    if (rst && stall_prev) begin
      total++;
      if (bus.ofmap_valid !== 1'b1 || got !== stall_word) begin
        bad++;
        $display("FAIL hold_stable: valid=%b word=%h required valid=1 word=%h", bus.ofmap_valid, got, stall_word);
      end
    end
    stall_prev = rst && bus.ofmap_valid && !bus.ofmap_ready;
    stall_word = got;
    if (rst && bus.ofmap_valid && bus.ofmap_ready) begin
      write_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: word=%h required no write", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL write_word: f=%0d addr=%0d data=%h required f=%0d addr=%0d data=%h",
                   got[15:14], got[13:8], got[7:0], e[15:14], e[13:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_psum(input logic [1:0] f, input logic signed [11:0] p);
    bit ok;
    ok = 1'b0;
    bus.psum_in.valid      = 1'b1;
    bus.psum_in.filter_idx = f;
    bus.psum_in.psum       = p;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.psum_ack === 1'b1) ok = 1'b1;
    end
    bus.psum_in.valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout: no ack for f=%0d psum=%h", f, p);
    end else begin
      model_accept(f, p);
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.ofmap_valid === 1'b1) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL drain_timeout: %0d writes outstanding, required 0", exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int a0;
    rst = 1'b0; start = 1'b0; start2 = 1'b0;
    bus.psum_in = '0; bus2.psum_in = '0; bus2.ofmap_ready = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 6;
    if (bus.psum_ack !== 1'b0)    begin bad++; $display("FAIL rst_ack: got %b required 0", bus.psum_ack); end
    if (bus.ofmap_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", bus.ofmap_valid); end
    if ({bus.ofmap_filter_idx, bus.ofmap_addr, bus.ofmap_data} !== 16'h0)
      begin bad++; $display("FAIL rst_ofmap: got %h required 0", {bus.ofmap_filter_idx, bus.ofmap_addr, bus.ofmap_data}); end
    if (done !== 1'b0)            begin bad++; $display("FAIL rst_done: got %b required 0", done); end
    if (error !== 1'b0)           begin bad++; $display("FAIL rst_error: got %b required 0", error); end
    if (state_dbg !== ST_IDLE)    begin bad++; $display("FAIL rst_state: got %0d required %0d", state_dbg, ST_IDLE); end
    @(posedge clk); #1;
    rst = 1'b1;
    // valid offered in IDLE must stay pending
    a0 = ack_cnt;
    bus.psum_in = '{valid: 1'b1, filter_idx: 2'd0, psum: 12'sh020};
    repeat (5) @(posedge clk);
    @(negedge clk);
    total += 2;
    if (ack_cnt - a0 !== 0)       begin bad++; $display("FAIL idle_ack: got %0d acks required 0", ack_cnt - a0); end
    if (state_dbg !== ST_IDLE)    begin bad++; $display("FAIL idle_state: got %0d required %0d", state_dbg, ST_IDLE); end
    @(posedge clk); #1;
    bus.psum_in.valid = 1'b0;
  endtask

  task automatic test_single();
    do_start();
    @(negedge clk);
    total++;
    if (state_dbg !== ST_RUN) begin bad++; $display("FAIL start_state: got %0d required %0d", state_dbg, ST_RUN); end
    @(posedge clk); #1;
    send_psum(2'd0, 12'sh020);
    @(negedge clk);
    total++;
    if (bus.ofmap_valid !== 1'b0) begin bad++; $display("FAIL latency_early: valid=%b required 0", bus.ofmap_valid); end
    @(posedge clk); #1;
    total += 2;
    if (bus.psum_ack !== 1'b0) begin bad++; $display("FAIL ack_width: ack=%b required 0", bus.psum_ack); end
    if ({bus.ofmap_valid, bus.ofmap_filter_idx, bus.ofmap_addr, bus.ofmap_data} !== {1'b1, 2'd0, 6'd0, 8'h7f})
      begin bad++; $display("FAIL first_write: v=%b f=%0d a=%0d d=%h required v=1 f=0 a=0 d=7f",
                            bus.ofmap_valid, bus.ofmap_filter_idx, bus.ofmap_addr, bus.ofmap_data); end
    drain();
  endtask

  task automatic test_relu();
    bit ok;
    send_psum(2'd1, -12'sh010);
    drain();
    // same input through the instance without ReLU
    @(posedge clk); #1; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    bus2.psum_in = '{valid: 1'b1, filter_idx: 2'd1, psum: -12'sh010};
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(posedge clk); #1; if (bus2.psum_ack === 1'b1) ok = 1'b1; end
    bus2.psum_in.valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); if (bus2.ofmap_valid === 1'b1) ok = 1'b1; end
    total++;
    if (!ok || {bus2.ofmap_filter_idx, bus2.ofmap_addr, bus2.ofmap_data} !== {2'd1, 6'd0, 8'hc0})
      begin bad++; $display("FAIL norelu_write: seen=%b f=%0d a=%0d d=%h required f=1 a=0 d=c0",
                            ok, bus2.ofmap_filter_idx, bus2.ofmap_addr, bus2.ofmap_data); end
  endtask

  task automatic test_backpressure();
    int a0;
    do_start();
    ready_mode = 2;
    @(posedge clk); #1;
    a0 = ack_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) send_psum(2'(i), 12'($urandom_range(0, 4095)));
      end
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        total += 3;
        if (ack_cnt - a0 !== 2)       begin bad++; $display("FAIL bp_acks: got %0d required 2", ack_cnt - a0); end
        if (bus.ofmap_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b required 1", bus.ofmap_valid); end
        if (write_cnt < 0 || exp_q.size() !== 2) begin bad++; $display("FAIL bp_queued: got %0d required 2", exp_q.size()); end
        ready_mode = 0;
      end
    join
    drain();
  endtask

  task automatic test_full_run();
    int seq[220];
    int wc0;
    int j, t;
    bit ok;
    do_start();
    ready_mode = 1;
    for (int i = 0; i < 220; i++) seq[i] = i % 4;
    for (int i = 219; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = seq[i]; seq[i] = seq[j]; seq[j] = t;
    end
    wc0 = write_cnt;
    for (int i = 0; i < 220; i++) send_psum(2'(seq[i]), 12'($urandom_range(0, 4095)));
    drain();
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin @(negedge clk); if (done === 1'b1) ok = 1'b1; end
    total += 3;
    if (!ok)                 begin bad++; $display("FAIL full_done: got %b required 1", done); end
    if (error !== 1'b0)      begin bad++; $display("FAIL full_error: got %b required 0", error); end
    if (write_cnt - wc0 !== 220) begin bad++; $display("FAIL full_count: got %0d writes required 220", write_cnt - wc0); end
  endtask

  task automatic test_overflow();
    int wc;
    ready_mode = 0;
    wc = write_cnt;
    send_psum(2'd2, 12'sh001);
    repeat (10) @(posedge clk);
    @(negedge clk);
    total += 3;
    if (write_cnt !== wc)     begin bad++; $display("FAIL ovf_write: got %0d writes required 0", write_cnt - wc); end
    if (error !== model_err)  begin bad++; $display("FAIL ovf_error: got %b required %b", error, model_err); end
    if (done !== 1'b1)        begin bad++; $display("FAIL ovf_done: got %b required 1", done); end
    do_start();
    @(negedge clk);
    total += 3;
    if (error !== 1'b0)       begin bad++; $display("FAIL restart_error: got %b required 0", error); end
    if (done !== 1'b0)        begin bad++; $display("FAIL restart_done: got %b required 0", done); end
    if (state_dbg !== ST_RUN) begin bad++; $display("FAIL restart_state: got %0d required %0d", state_dbg, ST_RUN); end
  endtask

  task automatic test_back_to_back();
    int a0;
    do_start();
    ready_mode = 1;
    a0 = ack_cnt;
    for (int i = 0; i < 30; i++)
      send_psum(2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)));
    drain();
    @(negedge clk);
    total += 2;
    if (ack_cnt - a0 !== 30)  begin bad++; $display("FAIL b2b_acks: got %0d required 30", ack_cnt - a0); end
    if (error !== model_err)  begin bad++; $display("FAIL b2b_error: got %b required %b", error, model_err); end
  endtask

  task automatic test_reset_mid();
    int wc;
    do_start();
    ready_mode = 2;
    @(posedge clk); #1;
    send_psum(2'd3, 12'sh00a);
    send_psum(2'd1, 12'sh00b);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total += 3;
    if (bus.ofmap_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b required 0", bus.ofmap_valid); end
    if (bus.psum_ack !== 1'b0)    begin bad++; $display("FAIL midrst_ack: got %b required 0", bus.psum_ack); end
    if (state_dbg !== ST_IDLE)    begin bad++; $display("FAIL midrst_state: got %0d required %0d", state_dbg, ST_IDLE); end
    model_clear();
    @(posedge clk); #1;
    rst = 1'b1;
    ready_mode = 0;
    wc = write_cnt;
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++;
    if (write_cnt !== wc) begin bad++; $display("FAIL midrst_nowrite: got %0d writes required 0", write_cnt - wc); end
    do_start();
    send_psum(2'd0, 12'sh008);
    drain();
    total++;
    if (write_cnt - wc !== 1) begin bad++; $display("FAIL midrst_resume: got %0d writes required 1", write_cnt - wc); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_relu();
    test_backpressure();
    test_full_run();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
